id_sequence_ctrl: RTL and testbench
===================================

# id_sequence_ctrl

Sequencer that drives the `data_in` advance input of the student-ID digit FSM. It issues one-cycle step pulses, either automatically at a programmable interval or on manual requests, for exactly one full 9-state cycle (s0 → s8 → s0). It tracks the expected FSM position and optionally cross-checks the FSM's `current_state` feedback. It sits between the board-level controls (buttons/switches) and the digit FSM.

## Interface
Parameters:
- NUM_STATES, 9, number of FSM states in one sequence
- TICK_W, 16, width of interval counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a run (pulse; sampled in IDLE only)
- stop  in  1  abort run, return to IDLE
- auto_mode  in  1  1 = timed stepping, 0 = manual; latched at start
- interval  in  TICK_W  cycles between steps in auto mode; latched at start
- step_req  in  1  manual step request (pulse)
- fsm_state  in  4  `current_state` feedback from digit FSM
- step_out  out  1  to FSM `data_in`; high exactly one cycle per step
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on entry to IDLE from DONE
- pos  out  4  expected FSM position, 0..NUM_STATES-1
- mismatch  out  1  sticky feedback error flag

## Operation
- States: IDLE, WAIT, STEP, CHECK, DONE.
- IDLE: busy=0. On start (and stop=0):
  - latch auto_mode and interval; clear mismatch; pos=0.
  - If check enabled and fsm_state≠0: set mismatch, go to DONE.
  - Otherwise go to WAIT.
- WAIT:
  - Auto: load counter with max(interval,1); decrement each cycle; at 1 → STEP. Interval 0 is treated as 1.
  - Manual: stay until step_req=1, then → STEP. step_req is ignored in all other states and in auto mode. There is no queueing.
- STEP: step_out=1 for one cycle; pos ← (pos==NUM_STATES-1) ? 0 : pos+1; → CHECK.
- CHECK: compare fsm_state with pos (check enabled).
  - Mismatch: set mismatch, → DONE.
  - Else if pos==0 (wrapped after 9 steps): → DONE.
  - Else → WAIT.
- DONE: one cycle; → IDLE with done=1 in the cycle after DONE.
- stop in any non-IDLE state → IDLE next edge, no done pulse, pos held. stop wins over start and over step_req in the same cycle.
- start while busy is ignored.

## Timing
- Reset values: step_out=0, busy=0, done=0, pos=0, mismatch=0, state IDLE, counter=0.
- All outputs are registered.
- step_out is high in cycle T; the FSM advances at the end of T; fsm_state is compared in T+1 (CHECK).
- Auto step period = max(interval,1)+2 cycles.
- Full auto run, start to done: 1 + 9·(max(interval,1)+2) + 1 cycles.
- Reset mid-run: immediate return to reset values; the controller does not reset the FSM. The board shares one reset net, inverted for the FSM's active-low input.
- mismatch persists through DONE/IDLE until the next accepted start or reset.

## Configuration
- MISMATCH_CHECK_EN defined: start-time and CHECK-state comparisons active; mismatch aborts the run.
- Not defined: comparisons removed, mismatch tied 0, fsm_state unused. The CHECK state is retained, so timing is identical in both builds.

## Structure
- Package id_seq_pkg holds:
  - the state enum (IDLE, WAIT, STEP, CHECK, DONE)
  - NUM_STATES, POS_W=4
  - the reset constants
- Sub-module interval_timer (load, enable, TICK_W down-counter, `expire` output) implements auto-mode WAIT.
- The top level holds the control FSM and the pos/mismatch registers.

## Test plan
- Auto, interval=3, fsm model correct → 9 step_out pulses spaced 5 cycles; pos 1..8,0; done pulse; mismatch=0.
- Manual, 9 step_req pulses with gaps, plus extra step_req during STEP/CHECK → exactly 9 step_out; extras ignored; done after 9th.
- MISMATCH_CHECK_EN, FSM model skips a state at step 4 → mismatch=1 in CHECK, run aborts, done pulses, pos=4.
- stop asserted together with step_req in WAIT after 2 steps → IDLE, no step_out, no done, pos=2.
- reset pulse mid-WAIT → all outputs 0 on the same edge; start afterward runs a full sequence.
- interval=0 in auto mode → step period 3 cycles; fsm_state≠0 at start (check enabled) → mismatch, no steps, done.

Source files
------------

// File: rtl/id_sequence_ctrl_pkg.sv
// Shared types and constants for the student-ID digit FSM sequencer.
package id_seq_pkg;

  localparam int NUM_STATES = 9;
  localparam int POS_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STEP,
    ST_CHECK,
    ST_DONE
  } seq_state_t;

  localparam seq_state_t       RST_STATE    = ST_IDLE;
  localparam logic [POS_W-1:0] RST_POS      = '0;
  localparam logic             RST_STEP     = 1'b0;
  localparam logic             RST_BUSY     = 1'b0;
  localparam logic             RST_DONE     = 1'b0;
  localparam logic             RST_MISMATCH = 1'b0;

  // Position after one step; wraps to 0 after the last state.
  function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] p, input int n);
    return (p == POS_W'(n - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/id_sequence_ctrl_if.sv
// Control/feedback bundle between board controls, the sequencer and the digit FSM.
interface id_sequence_ctrl_if #(
  parameter int TICK_W = 16
);
  import id_seq_pkg::*;

  logic              start;
  logic              stop;
  logic              auto_mode;
  logic [TICK_W-1:0] interval;
  logic              step_req;
  logic [3:0]        fsm_state;
  logic              step_out;
  logic              busy;
  logic              done;
  logic [POS_W-1:0]  pos;
  logic              mismatch;

  modport master (
    input  start, stop, auto_mode, interval, step_req, fsm_state,
    output step_out, busy, done, pos, mismatch
  );

  modport slave (
    output start, stop, auto_mode, interval, step_req, fsm_state,
    input  step_out, busy, done, pos, mismatch
  );

endinterface

// File: rtl/id_sequence_ctrl_interval_timer.sv
// Down-counter pacing auto-mode steps; a zero load value is treated as one.
module interval_timer #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [TICK_W-1:0] i_load_val,
  input  logic              i_en,
  output logic              o_expire
);

  logic [TICK_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= (i_load_val == '0) ? TICK_W'(1) : i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = i_en && (r_count == TICK_W'(1));

endmodule

// File: rtl/id_sequence_ctrl.sv
// Steps the digit FSM through one full cycle, timed or manual, tracking its position.
// Optional feature macro: MISMATCH_CHECK_EN enables fsm_state cross-checking.
module id_sequence_ctrl #(
  parameter int NUM_STATES = id_seq_pkg::NUM_STATES,
  parameter int TICK_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  id_sequence_ctrl_if.master bus
);
  import id_seq_pkg::*;

`ifdef MISMATCH_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic              r_auto;
  logic [TICK_W-1:0] r_interval;
  logic [POS_W-1:0]  r_pos;
  logic              r_step;
  logic              r_busy;
  logic              r_done;
  logic              r_mismatch;

  logic              w_start_ok;
  logic              w_start_fail;
  logic              w_chk_fail;
  logic              w_expire;
  logic              w_tmr_load;
  logic              w_tmr_en;
  logic [TICK_W-1:0] w_load_val;
  logic              w_step_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  assign w_start_ok   = (r_state == ST_IDLE) && bus.start && !bus.stop;
  assign w_start_fail = CHK_EN && (bus.fsm_state != 4'd0);
  assign w_chk_fail   = CHK_EN && (bus.fsm_state != r_pos);

  // The interval is latched on the same edge the timer is first loaded, so bypass it then.
  assign w_load_val = (r_state == ST_IDLE) ? bus.interval : r_interval;
  assign w_tmr_load = (w_next == ST_WAIT) && (r_state != ST_WAIT);
  assign w_tmr_en   = (r_state == ST_WAIT) && r_auto;

  interval_timer #(.TICK_W(TICK_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_load_val),
    .i_en       (w_tmr_en),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RST_STATE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if ((r_state != ST_IDLE) && bus.stop) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start_ok) w_next = w_start_fail ? ST_DONE : ST_WAIT;
        ST_WAIT:  if (r_auto ? w_expire : bus.step_req) w_next = ST_STEP;
        ST_STEP:  w_next = ST_CHECK;
        ST_CHECK: w_next = (w_chk_fail || (r_pos == '0)) ? ST_DONE : ST_WAIT;
        ST_DONE:  w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they align with r_state.
  always_comb begin
    w_step_nxt = (w_next == ST_STEP);
    w_busy_nxt = (w_next != ST_IDLE);
    w_done_nxt = (r_state == ST_DONE) && !bus.stop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step     <= RST_STEP;
      r_busy     <= RST_BUSY;
      r_done     <= RST_DONE;
      r_auto     <= 1'b0;
      r_interval <= '0;
      r_pos      <= RST_POS;
      r_mismatch <= RST_MISMATCH;
    end else begin
      r_step <= w_step_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_start_ok) begin
        r_auto     <= bus.auto_mode;
        r_interval <= bus.interval;
        r_pos      <= '0;
        r_mismatch <= w_start_fail;
      end else begin
        if ((r_state == ST_STEP) && !bus.stop)
          r_pos <= pos_next(r_pos, NUM_STATES);
        if ((r_state == ST_CHECK) && !bus.stop && w_chk_fail)
          r_mismatch <= 1'b1;
      end
    end
  end

  assign bus.step_out = r_step;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pos      = r_pos;
  assign bus.mismatch = r_mismatch;

endmodule

// File: tb/tb_id_sequence_ctrl.sv
// Randomized self-checking bench for id_sequence_ctrl with a behavioural digit-FSM model.
module tb_id_sequence_ctrl;

  localparam int TICK_W = 16;
  localparam int MAXS   = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_sequence_ctrl_if #(.TICK_W(TICK_W)) bus ();

  id_sequence_ctrl #(.NUM_STATES(9), .TICK_W(TICK_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Digit FSM stand-in: advances one state per step_out, optionally skipping one state.
  logic [3:0] fsm_q;
  int         fsm_steps;
  int         skip_at;
  logic       ovr_en;
  logic [3:0] ovr_val;
  bit         ovr_req;

  function automatic logic [3:0] fsm_adv(input logic [3:0] q);
    return (q == 4'd8) ? 4'd0 : q + 4'd1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q     <= 4'd0;
      fsm_steps <= 0;
    end else if (bus.step_out) begin
      fsm_steps <= fsm_steps + 1;
      fsm_q     <= (skip_at == fsm_steps + 1) ? fsm_adv(fsm_adv(fsm_q)) : fsm_adv(fsm_q);
    end
  end

  assign bus.fsm_state = ovr_en ? ovr_val : fsm_q;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   req_at   [MAXS];
  bit   stop_at  [MAXS];
  bit   start_at [MAXS];
  bit   exp_step [MAXS];
  logic [7:0] obs [MAXS];

  task automatic clear_sched();
    for (int i = 0; i < MAXS; i++) begin
      req_at[i] = 0; stop_at[i] = 0; start_at[i] = 0; exp_step[i] = 0;
    end
    ovr_req = 0;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.stop = 0; bus.auto_mode = 0; bus.interval = '0;
    bus.step_req = 0; ovr_en = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #3;
    reset = 1;
    @(posedge clk); #3;
    reset = 0;
  endtask

  // Plays the schedule; slot 0 carries start, obs[s] holds outputs after edge s.
  task automatic drive_run(input bit am, input logic [TICK_W-1:0] iv, input int nslots);
    @(posedge clk); #1;
    for (int s = 0; s <= nslots; s++) begin
      if (s > 0) begin @(posedge clk); #1; end
      obs[s] = {bus.step_out, bus.busy, bus.done, bus.mismatch, bus.pos};
      bus.start     = (s == 0) || start_at[s];
      bus.auto_mode = (s == 0) ? am : 1'($urandom_range(0, 1));
      bus.interval  = (s == 0) ? iv : TICK_W'($urandom);
      bus.step_req  = req_at[s];
      bus.stop      = stop_at[s];
      ovr_en        = (s == 0) && ovr_req;
    end
    idle_inputs();
  endtask

  // Expected {step_out, busy, done, mismatch, pos} at slot s. Busy through slot e.
  function automatic logic [7:0] model_vec(input int s, input int e, input bit done_f, input int mm_slot);
    int n = 0;
    for (int i = 1; i < s; i++) if (exp_step[i]) n++;
    return {exp_step[s], (s >= 1 && s <= e), (done_f && s == e + 1),
            (mm_slot >= 0 && s >= mm_slot), 4'(n % 9)};
  endfunction

  task automatic test_reset();
    logic [7:0] v;
    #1;
    v = {bus.step_out, bus.busy, bus.done, bus.mismatch, bus.pos};
    n_checks++;
    if (v !== 8'h00) $display("FAIL reset_held: got %b expected %b", v, 8'h00);
    else n_pass++;
    @(negedge clk); reset = 0;
    repeat (2) @(posedge clk);
    #1;
    v = {bus.step_out, bus.busy, bus.done, bus.mismatch, bus.pos};
    n_checks++;
    if (v !== 8'h00) $display("FAIL reset_idle: got %b expected %b", v, 8'h00);
    else n_pass++;
  endtask

  // Auto run: step k lands at slot k*(N+2)-1, extra start pulses while busy are ignored.
  task automatic test_auto(input string name, input logic [TICK_W-1:0] iv, input bit do_rst);
    int nn, e, nslots;
    logic [7:0] ev;
    if (do_rst) do_reset();
    clear_sched();
    nn = (iv == 0) ? 1 : int'(iv);
    for (int k = 1; k <= 9; k++) exp_step[k * (nn + 2) - 1] = 1;
    e = 9 * (nn + 2) + 1;
    for (int i = 0; i < 3; i++) start_at[$urandom_range(2, e)] = 1;
    nslots = e + 3;
    drive_run(1'b1, iv, nslots);
    for (int s = 1; s <= nslots; s++) begin
      ev = model_vec(s, e, 1'b1, -1);
      n_checks++;
      if (obs[s] !== ev) $display("FAIL %s slot %0d: got %b expected %b", name, s, obs[s], ev);
      else n_pass++;
    end
  endtask

  task automatic test_manual();
    int ws, r, e, nslots;
    logic [7:0] ev;
    do_reset();
    clear_sched();
    req_at[0] = 1;
    ws = 1;
    r  = 0;
    for (int k = 1; k <= 9; k++) begin
      r = ws + $urandom_range(0, 3);
      req_at[r] = 1; req_at[r + 1] = 1; req_at[r + 2] = 1;
      exp_step[r + 1] = 1;
      ws = r + 3;
    end
    e = r + 3;
    nslots = e + 3;
    drive_run(1'b0, TICK_W'($urandom_range(1, 4)), nslots);
    for (int s = 1; s <= nslots; s++) begin
      ev = model_vec(s, e, 1'b1, -1);
      n_checks++;
      if (obs[s] !== ev) $display("FAIL manual slot %0d: got %b expected %b", s, obs[s], ev);
      else n_pass++;
    end
  endtask

  task automatic test_stop_with_req();
    int ws, r, nslots;
    logic [7:0] ev;
    do_reset();
    clear_sched();
    ws = 1;
    for (int k = 1; k <= 2; k++) begin
      r = ws + $urandom_range(0, 3);
      req_at[r] = 1;
      exp_step[r + 1] = 1;
      ws = r + 3;
    end
    r = ws + $urandom_range(0, 3);
    req_at[r] = 1; stop_at[r] = 1;
    nslots = r + 4;
    drive_run(1'b0, TICK_W'(2), nslots);
    for (int s = 1; s <= nslots; s++) begin
      ev = model_vec(s, r, 1'b0, -1);
      n_checks++;
      if (obs[s] !== ev) $display("FAIL stop_with_req slot %0d: got %b expected %b", s, obs[s], ev);
      else n_pass++;
    end
  endtask

  task automatic test_mismatch_skip();
    int nn, e, mm, nslots, last;
    logic [7:0] ev;
    do_reset();
    clear_sched();
    skip_at = 4;
    nn = $urandom_range(1, 4);
`ifdef MISMATCH_CHECK_EN
    last = 4;
`else
    last = 9;
`endif
    for (int k = 1; k <= last; k++) exp_step[k * (nn + 2) - 1] = 1;
    e = last * (nn + 2) + 1;
`ifdef MISMATCH_CHECK_EN
    mm = e;
`else
    mm = -1;
`endif
    nslots = e + 3;
    drive_run(1'b1, TICK_W'(nn), nslots);
    skip_at = 0;
    for (int s = 1; s <= nslots; s++) begin
      ev = model_vec(s, e, 1'b1, mm);
      n_checks++;
      if (obs[s] !== ev) $display("FAIL mismatch_skip slot %0d: got %b expected %b", s, obs[s], ev);
      else n_pass++;
    end
  endtask

  task automatic test_start_mismatch();
    int e, mm, nslots;
    logic [7:0] ev;
    do_reset();
    clear_sched();
    ovr_req = 1;
    ovr_val = 4'($urandom_range(1, 15));
`ifdef MISMATCH_CHECK_EN
    e = 1; mm = 1;
`else
    for (int k = 1; k <= 9; k++) exp_step[k * 3 - 1] = 1;
    e = 28; mm = -1;
`endif
    nslots = e + 3;
    drive_run(1'b1, TICK_W'(1), nslots);
    ovr_req = 0;
    for (int s = 1; s <= nslots; s++) begin
      ev = model_vec(s, e, 1'b1, mm);
      n_checks++;
      if (obs[s] !== ev) $display("FAIL start_mismatch slot %0d: got %b expected %b", s, obs[s], ev);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] v;
    do_reset();
    @(posedge clk); #1;
    bus.start = 1; bus.auto_mode = 1; bus.interval = TICK_W'(5);
    @(posedge clk); #1;
    bus.start = 0;
    @(posedge clk); #1;
    v = {bus.step_out, bus.busy, bus.done, bus.mismatch, bus.pos};
    n_checks++;
    if (v !== 8'h40) $display("FAIL mid_run_busy: got %b expected %b", v, 8'h40);
    else n_pass++;
    #2; reset = 1; #1;
    v = {bus.step_out, bus.busy, bus.done, bus.mismatch, bus.pos};
    n_checks++;
    if (v !== 8'h00) $display("FAIL mid_run_reset: got %b expected %b", v, 8'h00);
    else n_pass++;
    @(posedge clk); #3;
    reset = 0;
    idle_inputs();
    test_auto("after_reset", TICK_W'($urandom_range(1, 5)), 1'b0);
  endtask

  initial begin
    reset = 1;
    skip_at = 0;
    ovr_val = 4'd0;
    clear_sched();
    idle_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_auto("auto_iv3", TICK_W'(3), 1'b1);
    test_auto("auto_iv0", TICK_W'(0), 1'b1);
    test_auto("auto_rand", TICK_W'($urandom_range(1, 6)), 1'b1);
    test_manual();
    test_stop_with_req();
    test_mismatch_skip();
    test_start_mismatch();
    test_reset_mid_run();
    test_auto("back_to_back_a", TICK_W'($urandom_range(1, 4)), 1'b1);
    test_auto("back_to_back_b", TICK_W'($urandom_range(0, 4)), 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
